mem_lane_unit: RTL

- Parametrised byte-lane access unit between the MEM pipeline stage and the data-memory bus.
- Generates lane enables for byte, half, word and dword accesses, and replicates store data across lanes.
- Extracts and sign/zero-extends load data, and detects misaligned or illegal accesses.
- Sequences each access through a req/ack handshake, with one outstanding transaction at a time.

---
 rtl/mem_lane_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_lane_unit.sv
// Byte-lane access unit between MEM stage and data bus: lane enables, store replication,
// load extraction/extension, fault detection. Define MISALIGN_TRAP_EN to trap misaligned accesses.

module mem_lane_slice #(
  parameter int DATA_W = 32,
  parameter int LANE   = 0,
  parameter int OFS_W  = 2
) (
  input  logic [OFS_W-1:0]  off,
  input  logic [3:0]        nbytes,
  input  logic [DATA_W-1:0] wdata,
  output logic              be,
  output logic [7:0]        wbyte
);
  localparam logic [3:0] IDX = 4'(LANE);
  logic [3:0]       off4;
  logic [OFS_W-1:0] src;

  assign off4  = 4'(off);
  // nbytes is a power of two, so the replicated source byte is LANE mod nbytes
  assign src   = OFS_W'(LANE) & OFS_W'(nbytes - 4'd1);
  assign be    = (IDX >= off4) && (IDX < off4 + nbytes);
  assign wbyte = wdata[{src, 3'b000} +: 8];
endmodule

module mem_lane_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_exc
);
  localparam int LANES = DATA_W / 8;
  localparam int OFS_W = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_nxt;

  logic [OFS_W-1:0] off_raw, amask, off;
  logic [3:0]       nbytes;
  logic             fault_size, exc;

  assign off_raw    = req_addr[OFS_W-1:0];
  assign nbytes     = 4'd1 << req_size;
  assign amask      = OFS_W'(nbytes - 4'd1);
  assign fault_size = (DATA_W == 32) && (req_size == 2'b11);

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = |(off_raw & amask);
  assign off      = off_raw;
  assign exc      = fault_size | misalign;
`else
  // round misaligned offsets down to natural alignment instead of trapping
  assign off      = off_raw & ~amask;
  assign exc      = fault_size;
`endif

  logic [LANES-1:0]      be_nxt;
  logic [LANES-1:0][7:0] wd_nxt;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mem_lane_slice #(.DATA_W(DATA_W), .LANE(i), .OFS_W(OFS_W)) u_lane (
      .off   (off),
      .nbytes(nbytes),
      .wdata (req_wdata),
      .be    (be_nxt[i]),
      .wbyte (wd_nxt[i])
    );
  end

  logic              we_q, uns_q, exc_q;
  logic [1:0]        size_q;
  logic [OFS_W-1:0]  off_q;
  logic [LANES-1:0]  be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  // load extraction from the latched request
  logic [DATA_W-1:0] shifted, ext;
  logic [6:0]        nbits;
  logic              sgn;

  assign shifted = mem_rdata >> {off_q, 3'b000};
  assign nbits   = 7'd8 << size_q;

  always_comb begin
    sgn = 1'b0;
    ext = '0;
    case (size_q)
      2'b00:   sgn = shifted[7];
      2'b01:   sgn = shifted[15];
      2'b10:   sgn = shifted[31];
      default: sgn = shifted[DATA_W-1];
    endcase
    for (int j = 0; j < DATA_W; j++)
      ext[j] = (j < int'(nbits)) ? shifted[j] : (~uns_q & sgn);
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = exc ? RESP : BUSY;
      BUSY:    if (mem_ack)   state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      exc_q   <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (state == IDLE && req_valid) begin
      we_q    <= req_we;
      uns_q   <= req_unsigned;
      exc_q   <= exc;
      size_q  <= req_size;
      off_q   <= off;
      be_q    <= be_nxt;
      addr_q  <= {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
      wdata_q <= wd_nxt;
      rdata_q <= '0;
    end else if (state == BUSY && mem_ack) begin
      rdata_q <= we_q ? '0 : ext;
    end
  end

  assign req_ready = (state == IDLE);
  assign mem_req   = (state == BUSY);
  assign mem_we    = (state == BUSY) & we_q;
  assign mem_be    = (state == BUSY) ? be_q : '0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = (state == RESP) ? rdata_q : '0;
  assign rsp_exc   = (state == RESP) & exc_q;
endmodule
